// File: rtl/wb_bot_pkg.sv
// wb_bot_pkg: register map constants, ID word and FSM state type for wb_bot_regbank
package wb_bot_pkg;

    localparam int OFS_INFO     = 'h0;
    localparam int OFS_CTRL     = 'h4;
    localparam int OFS_STATUS   = 'h8;
    localparam int OFS_INT_EN   = 'h0;
    localparam int OFS_INT_PEND = 'h4;
    localparam int OFS_ID       = 'h8;

    localparam logic [15:0] ID_MAGIC = 16'hB07A;
    localparam logic [7:0]  ID_REV   = 8'h02;

    localparam int ST_PEND = 0;
    localparam int ST_OVR  = 1;

    typedef enum logic {S_IDLE, S_RESP} wb_state_t;

    function automatic logic [31:0] id_word(input int nbots);
        return {ID_MAGIC, 8'(nbots), ID_REV};
    endfunction

endpackage

// File: rtl/bot_chan_regs.sv
// bot_chan_regs: one channel's INFO snapshot, CTRL register and sticky PEND/OVR status
module bot_chan_regs
    import wb_bot_pkg::*;
#(
    parameter logic [7:0] CTRL_RST = 8'h00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        upd,
    input  logic [31:0] info_in,
    input  logic        ctrl_we,
    input  logic [7:0]  ctrl_wdata,
    input  logic        clr_pend,
    input  logic        clr_ovr,
    output logic [31:0] info,
    output logic [7:0]  ctrl,
    output logic [1:0]  status
);

    logic pend;
    logic ovr;

    // an update always wins over a same-cycle clear, and never counts as an overrun then
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            info <= '0;
            ctrl <= CTRL_RST;
            pend <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (upd)
                info <= info_in;
            if (ctrl_we)
                ctrl <= ctrl_wdata;
            pend <= upd | (pend & ~clr_pend);
            ovr  <= (upd & pend & ~clr_pend) | (ovr & ~clr_ovr);
        end
    end

    always_comb begin
        status          = '0;
        status[ST_PEND] = pend;
        status[ST_OVR]  = ovr;
    end

endmodule

// File: rtl/wb_bot_regbank.sv
// wb_bot_regbank: Wishbone slave exposing NUM_BOTS bot channels plus global interrupt registers
module wb_bot_regbank
    import wb_bot_pkg::*;
#(
    parameter int                NUM_BOTS    = 2,
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] BOT_STRIDE  = 'h20,
    parameter logic [ADDR_W-1:0] GLOBAL_BASE = 'h100,
    parameter logic [7:0]        CTRL_RST    = 8'h00
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_W-1:0]     wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    input  logic [NUM_BOTS*32-1:0] bot_info_i,
    input  logic [NUM_BOTS-1:0]   bot_upd_i,
    output logic [NUM_BOTS*8-1:0] bot_ctrl_o,
    output logic                  irq_o
);

    localparam int SH = $clog2(BOT_STRIDE);

    wb_state_t state;
    wb_state_t state_nxt;

    logic [ADDR_W-1:0] adr;
    logic [ADDR_W-1:0] ofs;
    logic [ADDR_W-1:0] gofs;
    logic [ADDR_W-1:0] chan;
    logic accept;
    logic wr;
    logic in_glob;
    logic glob_hit;
    logic chan_hit;
    logic hit;
    logic [NUM_BOTS-1:0] chan_sel;
    logic [NUM_BOTS-1:0] int_en;
    logic [NUM_BOTS-1:0] pend;
    logic [NUM_BOTS-1:0] ctrl_we;
    logic [NUM_BOTS-1:0] clr_pend;
    logic [NUM_BOTS-1:0] clr_ovr;
    logic [31:0] info [NUM_BOTS];
    logic [7:0]  ctrl [NUM_BOTS];
    logic [1:0]  status [NUM_BOTS];
    logic [31:0] rd_data;
    logic unused_bits;

    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

    // offsets 0/4/8 are contiguous, so a word-aligned offset <= 8 is a mapped slot
    assign adr      = {wb_adr_i[ADDR_W-1:2], 2'b00};
    assign ofs      = adr & (BOT_STRIDE - ADDR_W'(1));
    assign chan     = adr >> SH;
    assign gofs     = adr - GLOBAL_BASE;
    assign in_glob  = adr >= GLOBAL_BASE;
    assign glob_hit = in_glob && gofs <= ADDR_W'(OFS_ID);
    assign chan_hit = !in_glob && chan < ADDR_W'(NUM_BOTS) && ofs <= ADDR_W'(OFS_STATUS);
    assign hit      = glob_hit | chan_hit;

    assign accept = wb_cyc_i & wb_stb_i & (state == S_IDLE);
    assign wr     = accept & wb_we_i;

    for (genvar i = 0; i < NUM_BOTS; i++) begin : g_chan
        assign chan_sel[i] = chan_hit && chan == ADDR_W'(i);
        assign ctrl_we[i]  = wr & chan_sel[i] & (ofs == ADDR_W'(OFS_CTRL)) & wb_sel_i[0];
        assign clr_pend[i] = wr & chan_sel[i] & (ofs == ADDR_W'(OFS_STATUS)) & wb_sel_i[0] & wb_dat_i[ST_PEND];
        assign clr_ovr[i]  = wr & chan_sel[i] & (ofs == ADDR_W'(OFS_STATUS)) & wb_sel_i[0] & wb_dat_i[ST_OVR];
        bot_chan_regs #(
            .CTRL_RST(CTRL_RST)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .upd       (bot_upd_i[i]),
            .info_in   (bot_info_i[32*i +: 32]),
            .ctrl_we   (ctrl_we[i]),
            .ctrl_wdata(wb_dat_i[7:0]),
            .clr_pend  (clr_pend[i]),
            .clr_ovr   (clr_ovr[i]),
            .info      (info[i]),
            .ctrl      (ctrl[i]),
            .status    (status[i])
        );
        assign pend[i]              = status[i][ST_PEND];
        assign bot_ctrl_o[8*i +: 8] = ctrl[i];
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_BOTS; k++)
            if (chan_sel[k])
                rd_data = ofs == ADDR_W'(OFS_INFO) ? info[k] :
                          ofs == ADDR_W'(OFS_CTRL) ? 32'(ctrl[k]) : 32'(status[k]);
        if (glob_hit)
            rd_data = gofs == ADDR_W'(OFS_INT_EN)   ? 32'(int_en) :
                      gofs == ADDR_W'(OFS_INT_PEND) ? 32'(pend) : id_word(NUM_BOTS);
    end

    always_comb begin
        state_nxt = accept ? S_RESP : S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            int_en   <= '0;
            irq_o    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wb_ack_o <= accept & hit;
            wb_err_o <= accept & ~hit;
            wb_dat_o <= (accept & hit & ~wb_we_i) ? rd_data : '0;
            if (wr & glob_hit & (gofs == ADDR_W'(OFS_INT_EN)) & wb_sel_i[0])
                int_en <= wb_dat_i[NUM_BOTS-1:0];
            irq_o    <= |(pend & int_en);
        end
    end

endmodule

// File: tb/tb_wb_bot_regbank.sv
// tb_wb_bot_regbank: directed plus randomized Wishbone/bot traffic checked against a register-map model
`timescale 1ns/1ps
module tb_wb_bot_regbank;

    localparam int         NB   = 2;
    localparam logic [7:0] CRST = 8'hA5;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [11:0]     wb_adr_i = '0;
    logic [31:0]     wb_dat_i = '0;
    logic [3:0]      wb_sel_i = '0;
    logic            wb_we_i = 1'b0;
    logic            wb_cyc_i = 1'b0;
    logic            wb_stb_i = 1'b0;
    logic [31:0]     wb_dat_o;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic [NB*32-1:0] bot_info_i = '0;
    logic [NB-1:0]   bot_upd_i = '0;
    logic [NB*8-1:0] bot_ctrl_o;
    logic            irq_o;

    int checks = 0;
    int failures = 0;

    logic [31:0]   info_m [NB];
    logic [7:0]    ctrl_m [NB];
    logic [NB-1:0] pend_m;
    logic [NB-1:0] ovr_m;
    logic [NB-1:0] en_m;
    logic          irq_m;
    logic [31:0]   rd_last;

    always #5 clk = ~clk;

    wb_bot_regbank #(
        .NUM_BOTS(NB),
        .ADDR_W(12),
        .BOT_STRIDE(12'h20),
        .GLOBAL_BASE(12'h100),
        .CTRL_RST(CRST)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .bot_info_i(bot_info_i),
        .bot_upd_i (bot_upd_i),
        .bot_ctrl_o(bot_ctrl_o),
        .irq_o     (irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            info_m[i] = '0;
            ctrl_m[i] = CRST;
        end
        pend_m = '0;
        ovr_m  = '0;
        en_m   = '0;
        irq_m  = 1'b0;
    endtask

    // map a byte address onto the register map: returns 1 if mapped
    function automatic logic decode(input logic [11:0] adr, output int ch, output int ofs, output logic glob);
        int a;
        a = int'({adr[11:2], 2'b00});
        glob = a >= 'h100;
        ch = glob ? 0 : a / 'h20;
        ofs = glob ? a - 'h100 : a % 'h20;
        return glob ? (ofs <= 8) : (ch < NB && ofs <= 8);
    endfunction

    // advance the model over one clock edge using the inputs present at that edge
    task automatic model_edge(input logic acc, input logic we, input logic [11:0] adr, input logic [31:0] wd,
                              input logic [3:0] sel, output logic ok, output logic [31:0] rexp);
        int ch;
        int ofs;
        logic glob;
        logic [NB-1:0] cp;
        logic [NB-1:0] co;
        logic [NB-1:0] p0;
        cp = '0;
        co = '0;
        p0 = pend_m;
        ok = decode(adr, ch, ofs, glob);
        rexp = 32'h0;
        if (ok && glob)
            rexp = ofs == 0 ? 32'(en_m) : ofs == 4 ? 32'(pend_m) : {16'hB07A, 8'(NB), 8'h02};
        else if (ok)
            rexp = ofs == 0 ? info_m[ch] : ofs == 4 ? 32'(ctrl_m[ch]) : {30'b0, ovr_m[ch], pend_m[ch]};
        irq_m = |(pend_m & en_m);
        if (acc && ok && we && sel[0]) begin
            if (glob && ofs == 0) en_m = wd[NB-1:0];
            if (!glob && ofs == 4) ctrl_m[ch] = wd[7:0];
            if (!glob && ofs == 8) begin
                cp[ch] = wd[0];
                co[ch] = wd[1];
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (bot_upd_i[i]) info_m[i] = bot_info_i[32*i +: 32];
            ovr_m[i]  = (bot_upd_i[i] && p0[i] && !cp[i]) ? 1'b1 : co[i] ? 1'b0 : ovr_m[i];
            pend_m[i] = bot_upd_i[i] ? 1'b1 : cp[i] ? 1'b0 : pend_m[i];
        end
    endtask

    task automatic chk_outs(input string tag);
        logic [NB*8-1:0] c;
        for (int i = 0; i < NB; i++) c[8*i +: 8] = ctrl_m[i];
        chk({tag, ".ctrl"}, 32'(bot_ctrl_o), 32'(c));
        chk({tag, ".irq"}, 32'(irq_o), 32'(irq_m));
    endtask

    task automatic tick(input logic [NB-1:0] upd, input logic [NB*32-1:0] info);
        logic ok;
        logic [31:0] r;
        bot_upd_i = upd;
        bot_info_i = info;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, ok, r);
        #1;
        bot_upd_i = '0;
        chk("idle.term", 32'({wb_ack_o, wb_err_o}), 32'h0);
        chk_outs("idle");
    endtask

    task automatic wb(input logic we, input logic [11:0] adr, input logic [31:0] wd, input logic [3:0] sel,
                      input logic [NB-1:0] upd);
        logic ok;
        logic [31:0] r;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = wd;
        wb_sel_i = sel;
        bot_upd_i = upd;
        for (int i = 0; i < NB; i++) bot_info_i[32*i +: 32] = $urandom;
        @(posedge clk);
        model_edge(1'b1, we, adr, wd, sel, ok, r);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        bot_upd_i = '0;
        rd_last = wb_dat_o;
        chk($sformatf("ack@%h", adr), 32'(wb_ack_o), 32'(ok));
        chk($sformatf("err@%h", adr), 32'(wb_err_o), 32'(!ok));
        if (!we || !ok) chk($sformatf("dat@%h", adr), wb_dat_o, r);
        chk_outs("wb");
        @(posedge clk);
        model_edge(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, ok, r);
        #1;
        chk("wb.oneshot", 32'({wb_ack_o, wb_err_o}), 32'h0);
        chk_outs("wb.end");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] pool [20];
        logic [11:0] a;
        pool = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h01C, 12'h020, 12'h024, 12'h028, 12'h02C,
                 12'h040, 12'h044, 12'h0E8, 12'h0FC, 12'h100, 12'h104, 12'h108, 12'h10C, 12'h110, 12'hFFC};
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rst.dat", wb_dat_o, 32'h0);
        chk("rst.term", 32'({wb_ack_o, wb_err_o}), 32'h0);
        chk_outs("rst");

        wb(1'b0, 12'h108, 32'h0, 4'hF, '0);
        chk("id", rd_last, 32'hB07A0202);
        wb(1'b0, 12'h024, 32'h0, 4'hF, '0);
        chk("ctrl1_rst", rd_last, 32'(CRST));
        chk("irq_rst", 32'(irq_o), 32'h0);

        wb(1'b1, 12'h024, 32'h0000005A, 4'b0001, '0);
        chk("ctrl1_lane0", 32'(bot_ctrl_o[15:8]), 32'h5A);
        wb(1'b1, 12'h024, 32'hFFFFFFA0, 4'b1110, '0);
        chk("ctrl1_lane_hi", 32'(bot_ctrl_o[15:8]), 32'h5A);

        wb(1'b1, 12'h100, 32'h1, 4'b0001, '0);
        tick(2'b01, {32'hDEADBEEF, 32'h11223344});
        chk("irq_lat1", 32'(irq_o), 32'h0);
        tick('0, '0);
        chk("irq_set", 32'(irq_o), 32'h1);
        wb(1'b0, 12'h000, 32'h0, 4'hF, '0);
        chk("snap0", rd_last, 32'h11223344);
        wb(1'b1, 12'h008, 32'h1, 4'b0001, '0);
        chk("irq_clr", 32'(irq_o), 32'h0);

        tick(2'b01, {$urandom, $urandom});
        tick(2'b01, {$urandom, $urandom});
        wb(1'b0, 12'h008, 32'h0, 4'hF, '0);
        chk("ovr_status", rd_last, 32'h3);
        wb(1'b1, 12'h008, 32'h2, 4'b0001, '0);
        wb(1'b0, 12'h008, 32'h0, 4'hF, '0);
        chk("ovr_clr", rd_last, 32'h1);

        wb(1'b1, 12'h008, 32'h1, 4'b0001, 2'b01);
        wb(1'b0, 12'h008, 32'h0, 4'hF, '0);
        chk("set_wins", rd_last, 32'h1);

        wb(1'b0, 12'h040, 32'h0, 4'hF, '0);
        chk("unmap_rd_err", 32'({wb_ack_o, wb_err_o}), 32'h0);
        wb(1'b1, 12'h00C, 32'hFFFFFFFF, 4'hF, '0);
        wb(1'b0, 12'h008, 32'h0, 4'hF, '0);
        chk("unmap_noeffect", rd_last, 32'h1);

        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(7) == 0) ? 12'($urandom) : pool[$urandom_range(19)];
            if ($urandom_range(3) == 0)
                tick(NB'($urandom_range(0, 3) & $urandom_range(0, 3)), {$urandom, $urandom});
            else
                wb(1'($urandom), a, $urandom, $urandom_range(1) ? 4'hF : 4'($urandom),
                   NB'($urandom_range(0, 3) & $urandom_range(0, 3)));
        end

        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 12'h004;
        wb_dat_i = 32'h77;
        wb_sel_i = 4'hF;
        #2;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        tick('0, '0);
        chk("dropped_req", 32'(bot_ctrl_o[7:0]), 32'(ctrl_m[0]));

        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 12'h004;
        wb_dat_i = 32'h33;
        wb_sel_i = 4'b0001;
        @(posedge clk);
        #1;
        chk("midrst.ack", 32'(wb_ack_o), 32'h1);
        rstn = 1'b0;
        #1;
        chk("midrst.ack_drop", 32'({wb_ack_o, wb_err_o}), 32'h0);
        chk("midrst.ctrl", 32'(bot_ctrl_o), 32'({CRST, CRST}));
        chk("midrst.irq", 32'(irq_o), 32'h0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
        wb(1'b0, 12'h004, 32'h0, 4'hF, '0);
        chk("post_rst_ctrl0", rd_last, 32'(CRST));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
